// File: rtl/aemb2_sram_wbctl.sv
// Wishbone classic slave in front of a single-port synchronous SRAM.
// Byte-select writes that are not full-word become read-modify-write cycles.
module aemb2_sram_wbctl #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [AW-1:0]     wb_adr_i,
  input  logic [DW/8-1:0]   wb_sel_i,
  input  logic [DW-1:0]     wb_dat_i,
  output logic [DW-1:0]     wb_dat_o,
  output logic              wb_ack_o,
  output logic [AW-1:0]     ram_adr_o,
  output logic [DW-1:0]     ram_dat_o,
  output logic              ram_wre_o,
  output logic              ram_ena_o,
  input  logic [DW-1:0]     ram_dat_i
);

  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE, RD, MRG, ACK} state_t;

  state_t          state_r, state_nxt_s;
  logic [AW-1:0]   adr_r;
  logic [DW-1:0]   dat_r;
  logic [SW-1:0]   sel_r;
  logic [DW-1:0]   rdat_r;
  logic            ack_r, ack_nxt_s;
  logic            accept_s, load_rd_s;
  logic            ram_ena_s, ram_wre_s;
  logic [AW-1:0]   ram_adr_s;
  logic [DW-1:0]   ram_dat_s;
  logic            req_s;

  // Selected bytes come from the new data, the rest keep the old RAM word.
  function automatic logic [DW-1:0] merge_bytes(input logic [DW-1:0] new_d,
                                                input logic [DW-1:0] old_d,
                                                input logic [SW-1:0] sel);
    logic [DW-1:0] res;
    res = old_d;
    for (int i = 0; i < SW; i++) begin
      if (sel[i]) begin
        res[8*i +: 8] = new_d[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_d[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign req_s = wb_cyc_i & wb_stb_i;

  // Next-state, RAM strobes and ack decision.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = 1'b0;
    accept_s    = 1'b0;
    load_rd_s   = 1'b0;
    ram_ena_s   = 1'b0;
    ram_wre_s   = 1'b0;
    ram_adr_s   = adr_r;
    ram_dat_s   = dat_r;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          accept_s  = 1'b1;
          ram_adr_s = wb_adr_i;
          ram_dat_s = wb_dat_i;
          if (!wb_we_i) begin
            ram_ena_s   = 1'b1;
            state_nxt_s = RD;
          end else if (wb_sel_i == {SW{1'b1}}) begin
            ram_ena_s   = 1'b1;
            ram_wre_s   = 1'b1;
            ack_nxt_s   = 1'b1;
            state_nxt_s = ACK;
          end else if (wb_sel_i == {SW{1'b0}}) begin
            ack_nxt_s   = 1'b1;
            state_nxt_s = ACK;
          end else begin
            ram_ena_s   = 1'b1;
            state_nxt_s = MRG;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD: begin
        if (!wb_cyc_i) begin
          state_nxt_s = IDLE;
        end else begin
          load_rd_s   = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end
      end
      MRG: begin
        if (!wb_cyc_i) begin
          state_nxt_s = IDLE;
        end else begin
          ram_ena_s   = 1'b1;
          ram_wre_s   = 1'b1;
          ram_dat_s   = merge_bytes(dat_r, ram_dat_i, sel_r);
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK;
        end
      end
      ACK: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, latched request and registered bus outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
      rdat_r  <= {DW{1'b0}};
      adr_r   <= {AW{1'b0}};
      dat_r   <= {DW{1'b0}};
      sel_r   <= {SW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
      if (accept_s) begin
        adr_r <= wb_adr_i;
        dat_r <= wb_dat_i;
        sel_r <= wb_sel_i;
      end
      if (load_rd_s) begin
        rdat_r <= ram_dat_i;
      end
    end
  end

  // Reset must never let a strobe reach the RAM, even mid-operation.
  assign ram_ena_o = ram_ena_s & ~rst_i;
  assign ram_wre_o = ram_wre_s & ~rst_i;
  assign ram_adr_o = ram_adr_s;
  assign ram_dat_o = ram_dat_s;
  assign wb_ack_o  = ack_r;
  assign wb_dat_o  = rdat_r;

endmodule

// File: tb/tb_aemb2_sram_wbctl.sv
// Self-checking bench for aemb2_sram_wbctl with an SRAM model and a word-array reference.
module tb_aemb2_sram_wbctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  adr = 8'h00;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = 32'h0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [7:0]  ram_adr_o;
  logic [31:0] ram_dat_o;
  logic        ram_wre_o;
  logic        ram_ena_o;
  logic [31:0] ram_rdat = 32'h0;

  logic [31:0] mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] last_rd = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aemb2_sram_wbctl #(.AW(8), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .ram_adr_o(ram_adr_o), .ram_dat_o(ram_dat_o),
    .ram_wre_o(ram_wre_o), .ram_ena_o(ram_ena_o),
    .ram_dat_i(ram_rdat)
  );

  // Single-port synchronous SRAM, registered read.
  always @(posedge clk) begin
    if (ram_ena_o) begin
      if (ram_wre_o) mem[ram_adr_o] <= ram_dat_o;
      else           ram_rdat <= mem[ram_adr_o];
    end
  end

  function automatic logic [31:0] apply_write(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  // One complete WB access; cycle 0 is the request cycle. Bus released after ack.
  task automatic do_access(input logic w, input logic [7:0] a, input logic [3:0] s,
                           input logic [31:0] d, output int ack_cyc, output logic [31:0] rd,
                           output int n_ena, output int n_wre, output int wre_cyc);
    ack_cyc = -1; rd = 32'h0; n_ena = 0; n_wre = 0; wre_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d; end
      #1;
      if (ram_ena_o) n_ena++;
      if (ram_wre_o) begin n_wre++; if (wre_cyc < 0) wre_cyc = c; end
      if (wb_ack_o) begin ack_cyc = c; rd = wb_dat_o; break; end
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; we = 1'($urandom); sel = 4'($urandom);
    #1;
    n_checks++;
    if (wb_ack_o !== 1'b0) begin
      n_fail++; $display("FAIL ack_width: got %b exp 0 (adr %h)", wb_ack_o, a);
    end
    if (w) begin
      ref_mem[a] = apply_write(ref_mem[a], d, s);
    end else begin
      last_rd = rd;
    end
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      cyc = 1'b1; stb = 1'b1; we = 1'($urandom); sel = 4'hF; adr = 8'($urandom);
      #1;
      n_checks++;
      if (ram_ena_o !== 1'b0 || ram_wre_o !== 1'b0 || wb_ack_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_strobes: ena %b wre %b ack %b exp 000", ram_ena_o, ram_wre_o, wb_ack_o);
      end
      n_checks++;
      if (c > 0 && wb_dat_o !== 32'h0) begin
        n_fail++; $display("FAIL reset_dat: got %h exp 0", wb_dat_o);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic test_full_write();
    int ac, ne, nw, wc; logic [31:0] rd;
    do_access(1'b1, 8'h10, 4'hF, 32'hDEADBEEF, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 1 || nw !== 1 || wc !== 0) begin
      n_fail++; $display("FAIL full_write: ack_cyc %0d wre %0d wre_cyc %0d exp 1 1 0", ac, nw, wc);
    end
    do_access(1'b0, 8'h10, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 2 || rd !== 32'hDEADBEEF || nw !== 0) begin
      n_fail++; $display("FAIL full_readback: ack_cyc %0d dat %h wre %0d exp 2 deadbeef 0", ac, rd, nw);
    end
  endtask

  task automatic test_partial_write();
    int ac, ne, nw, wc; logic [31:0] rd;
    do_access(1'b1, 8'h05, 4'hF, 32'h11223344, ac, rd, ne, nw, wc);
    do_access(1'b1, 8'h05, 4'b0101, 32'hAABBCCDD, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 2 || nw !== 1 || wc !== 1) begin
      n_fail++; $display("FAIL partial_write: ack_cyc %0d wre %0d wre_cyc %0d exp 2 1 1", ac, nw, wc);
    end
    do_access(1'b0, 8'h05, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL partial_readback: got %h exp 11bb33dd", rd);
    end
  endtask

  task automatic test_zero_sel();
    int ac, ne, nw, wc; logic [31:0] rd;
    do_access(1'b1, 8'h05, 4'h0, 32'hFFFFFFFF, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 1 || ne !== 0) begin
      n_fail++; $display("FAIL zero_sel: ack_cyc %0d ena %0d exp 1 0", ac, ne);
    end
    do_access(1'b0, 8'h05, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    n_checks++;
    if (rd !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL zero_sel_readback: got %h exp 11bb33dd", rd);
    end
  endtask

  task automatic test_abort_mrg();
    int ac, ne, nw, wc, bad; logic [31:0] rd;
    do_access(1'b1, 8'h20, 4'hF, 32'hCAFEF00D, ac, rd, ne, nw, wc);
    bad = 0;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h20; sel = 4'b0011; wdat = 32'h12345678;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
      cyc = 1'b0;
      #1;
      if (ram_wre_o !== 1'b0 || wb_ack_o !== 1'b0) bad++;
    end
    stb = 1'b0;
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_mrg: got %0d cycles with wre/ack exp 0", bad);
    end
    do_access(1'b0, 8'h20, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 2 || rd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL abort_readback: ack_cyc %0d dat %h exp 2 cafef00d", ac, rd);
    end
  endtask

  task automatic test_reset_rd();
    int ac, ne, nw, wc; logic [31:0] rd;
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_checks++;
    if (ram_ena_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_rd_ena: got %b exp 0", ram_ena_o);
    end
    @(posedge clk); #2;
    n_checks++;
    if (wb_ack_o !== 1'b0 || wb_dat_o !== 32'h0 || ram_ena_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_rd: ack %b dat %h ena %b exp 0 0 0", wb_ack_o, wb_dat_o, ram_ena_o);
    end
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    do_access(1'b0, 8'h10, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    n_checks++;
    if (ac !== 2 || rd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rst_rd_after: ack_cyc %0d dat %h exp 2 deadbeef", ac, rd);
    end
  endtask

  task automatic test_random();
    int ac, ne, nw, wc, exp_ac, exp_ne, exp_nw;
    logic [31:0] rd, d; logic [7:0] a; logic [3:0] s; logic w;
    for (int i = 0; i < 8; i++) begin
      do_access(1'b1, 8'h40 + 8'(i), 4'hF, $urandom, ac, rd, ne, nw, wc);
    end
    do_access(1'b0, 8'h40, 4'h0, 32'h0, ac, rd, ne, nw, wc);
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 8'h40 + 8'($urandom_range(0, 7));
      s = 4'($urandom);
      d = $urandom;
      if (!w) begin exp_ac = 2; exp_ne = 1; exp_nw = 0; end
      else if (s == 4'hF) begin exp_ac = 1; exp_ne = 1; exp_nw = 1; end
      else if (s == 4'h0) begin exp_ac = 1; exp_ne = 0; exp_nw = 0; end
      else begin exp_ac = 2; exp_ne = 2; exp_nw = 1; end
      if (!w) begin
        do_access(w, a, s, d, ac, rd, ne, nw, wc);
        n_checks++;
        if (rd !== ref_mem[a]) begin
          n_fail++; $display("FAIL rand_read[%0d]: adr %h got %h exp %h", i, a, rd, ref_mem[a]);
        end
      end else begin
        do_access(w, a, s, d, ac, rd, ne, nw, wc);
        n_checks++;
        if (wb_dat_o !== last_rd) begin
          n_fail++; $display("FAIL rand_dat_hold[%0d]: got %h exp %h", i, wb_dat_o, last_rd);
        end
      end
      n_checks++;
      if (ac !== exp_ac || ne !== exp_ne || nw !== exp_nw) begin
        n_fail++; $display("FAIL rand_timing[%0d]: ack %0d ena %0d wre %0d exp %0d %0d %0d",
                           i, ac, ne, nw, exp_ac, exp_ne, exp_nw);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ac, ne, nw, wc, first, second, wide, adr_bad;
    logic [31:0] rd, d1, d2; logic prev;
    do_access(1'b1, 8'hFF, 4'hF, $urandom, ac, rd, ne, nw, wc);
    do_access(1'b1, 8'h00, 4'hF, $urandom, ac, rd, ne, nw, wc);
    first = -1; second = -1; wide = 0; adr_bad = 0; prev = 1'b0; d1 = 32'h0; d2 = 32'h0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hFF; end
      if (first >= 0 && c == first + 1) adr = 8'h00;
      #1;
      if (first >= 0 && c == first + 1 && (ram_adr_o !== 8'h00 || ram_ena_o !== 1'b1)) adr_bad++;
      if (wb_ack_o) begin
        if (prev) wide++;
        if (first < 0) begin first = c; d1 = wb_dat_o; end
        else if (second < 0) begin second = c; d2 = wb_dat_o; end
      end
      prev = wb_ack_o;
      if (second >= 0) break;
    end
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0;
    #1;
    if (wb_ack_o) wide++;
    n_checks++;
    if (first !== 2 || second !== 5 || wide !== 0) begin
      n_fail++; $display("FAIL b2b_timing: acks %0d %0d wide %0d exp 2 5 0", first, second, wide);
    end
    n_checks++;
    if (d1 !== ref_mem[8'hFF] || d2 !== ref_mem[8'h00] || adr_bad !== 0) begin
      n_fail++; $display("FAIL b2b_data: %h %h adr_bad %0d exp %h %h 0",
                         d1, d2, adr_bad, ref_mem[8'hFF], ref_mem[8'h00]);
    end
  endtask

  initial begin
    test_reset();
    test_full_write();
    test_partial_write();
    test_zero_sel();
    test_abort_mrg();
    test_reset_rd();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
